nms_peak_decide: RTL and testbench

Sequential non-maximum-suppression decision stage that sits directly downstream of the NMS score register bank. On a start pulse it latches the reference score and asserts the bank's read enable. It then compares the reference against the eight neighbour scores one per cycle and reports whether the reference is a local peak. Early exit on the first losing comparison keeps the average latency low, and a single comparator keeps area small.

---
 rtl/nms_peak_decide_if.sv | 38 +++
 rtl/nms_peak_decide.sv | 116 +++++++++++
 tb/tb_nms_peak_decide.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/nms_peak_decide_if.sv
// Bus between the NMS score register bank / requester and nms_peak_decide.
// master: bank side driving scores and start; slave: the decision stage.
interface nms_peak_decide_if #(
    parameter int SCORE_W = 12,
    parameter int CNT_W   = 16
);
    logic               start;
    logic [SCORE_W-1:0] thresh;
    logic [SCORE_W-1:0] refScore;
    logic [SCORE_W-1:0] nighScore0;
    logic [SCORE_W-1:0] nighScore1;
    logic [SCORE_W-1:0] nighScore2;
    logic [SCORE_W-1:0] nighScore3;
    logic [SCORE_W-1:0] nighScore4;
    logic [SCORE_W-1:0] nighScore5;
    logic [SCORE_W-1:0] nighScore6;
    logic [SCORE_W-1:0] nighScore7;
    logic               readEn;
    logic               busy;
    logic               done;
    logic               isPeak;
    logic [SCORE_W-1:0] peakScore;
    logic [CNT_W-1:0]   peakCount;

    modport master (
        output start, thresh, refScore,
        output nighScore0, nighScore1, nighScore2, nighScore3,
        output nighScore4, nighScore5, nighScore6, nighScore7,
        input  readEn, busy, done, isPeak, peakScore, peakCount
    );

    modport slave (
        input  start, thresh, refScore,
        input  nighScore0, nighScore1, nighScore2, nighScore3,
        input  nighScore4, nighScore5, nighScore6, nighScore7,
        output readEn, busy, done, isPeak, peakScore, peakCount
    );
endinterface

// File: rtl/nms_peak_decide.sv
// Sequential NMS peak decision: one neighbour compared per cycle, early exit on loss.
// Define NMS_TIEBREAK_EN to make neighbours 4..7 require a strict win (one peak per plateau).
module nms_peak_decide #(
    parameter int SCORE_W = 12,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               RESET,
    nms_peak_decide_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [SCORE_W-1:0] r_ref;
    logic [SCORE_W-1:0] w_ref_nx;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_nx;
    logic [SCORE_W-1:0] w_nigh;
    logic               w_win;
    logic               w_finish;
    logic               w_verdict;
    logic               r_readEn;
    logic               r_isPeak;
    logic [SCORE_W-1:0] r_peakScore;
    logic [CNT_W-1:0]   r_peakCount;

    always_comb begin
        case (r_idx)
            3'd0:    w_nigh = bus.nighScore0;
            3'd1:    w_nigh = bus.nighScore1;
            3'd2:    w_nigh = bus.nighScore2;
            3'd3:    w_nigh = bus.nighScore3;
            3'd4:    w_nigh = bus.nighScore4;
            3'd5:    w_nigh = bus.nighScore5;
            3'd6:    w_nigh = bus.nighScore6;
            default: w_nigh = bus.nighScore7;
        endcase
    end

`ifdef NMS_TIEBREAK_EN
    assign w_win = r_idx[2] ? (r_ref > w_nigh) : (r_ref >= w_nigh);
`else
    assign w_win = (r_ref >= w_nigh);
`endif

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // w_finish marks the edge into DONE; results are registered there so they are valid with done.
    always_comb begin
        w_next    = r_state;
        w_ref_nx  = r_ref;
        w_idx_nx  = r_idx;
        w_finish  = 1'b0;
        w_verdict = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_ref_nx = bus.refScore;
                    w_idx_nx = '0;
                    if (bus.refScore < bus.thresh) begin
                        w_next   = DONE;
                        w_finish = 1'b1;
                    end else begin
                        w_next = CMP;
                    end
                end
            end
            CMP: begin
                if (!w_win) begin
                    w_next   = DONE;
                    w_finish = 1'b1;
                end else if (r_idx == 3'd7) begin
                    w_next    = DONE;
                    w_finish  = 1'b1;
                    w_verdict = 1'b1;
                end else begin
                    w_idx_nx = r_idx + 3'd1;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_ref       <= '0;
            r_idx       <= '0;
            r_readEn    <= 1'b0;
            r_isPeak    <= 1'b0;
            r_peakScore <= '0;
            r_peakCount <= '0;
        end else begin
            r_ref    <= w_ref_nx;
            r_idx    <= w_idx_nx;
            r_readEn <= (w_next == CMP);
            if (w_finish) begin
                r_isPeak    <= w_verdict;
                r_peakScore <= w_verdict ? r_ref : '0;
                if (w_verdict && (r_peakCount != '1))
                    r_peakCount <= r_peakCount + CNT_W'(1);
            end
        end
    end

    assign bus.readEn    = r_readEn;
    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = (r_state == DONE);
    assign bus.isPeak    = r_isPeak;
    assign bus.peakScore = r_peakScore;
    assign bus.peakCount = r_peakCount;
endmodule

// File: tb/tb_nms_peak_decide.sv
// Self-checking bench for nms_peak_decide: directed table, random windows vs. a spec model,
// busy-ignore, mid-run reset and counter saturation (narrow counter build).
module tb_nms_peak_decide;
    localparam int SW = 12;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic RESET;
    always #5 clk = ~clk;

    nms_peak_decide_if #(.SCORE_W(SW), .CNT_W(CW)) u_if ();
    nms_peak_decide #(.SCORE_W(SW), .CNT_W(CW)) u_dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (u_if)
    );

    typedef struct {
        logic [SW-1:0]        rs;
        logic [SW-1:0]        th;
        logic [7:0][SW-1:0]   nb;
        int                   lat;
        bit                   pk;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;
    int model_cnt = 0;
    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Spec-level verdict: threshold gate, then scan neighbours in order, first loss ends it.
    function automatic void model(input logic [SW-1:0] rs, input logic [SW-1:0] th,
                                  input logic [7:0][SW-1:0] nb, output int lat, output bit pk);
        bit w;
        if (rs < th) begin
            lat = 1; pk = 1'b0; return;
        end
        for (int i = 0; i < 8; i++) begin
`ifdef NMS_TIEBREAK_EN
            w = (i < 4) ? (rs >= nb[i]) : (rs > nb[i]);
`else
            w = (rs >= nb[i]);
`endif
            if (!w) begin
                lat = i + 2; pk = 1'b0; return;
            end
        end
        lat = 9; pk = 1'b1;
    endfunction

    task automatic drive(input vec_t v);
        u_if.refScore   = v.rs;
        u_if.thresh     = v.th;
        u_if.nighScore0 = v.nb[0];
        u_if.nighScore1 = v.nb[1];
        u_if.nighScore2 = v.nb[2];
        u_if.nighScore3 = v.nb[3];
        u_if.nighScore4 = v.nb[4];
        u_if.nighScore5 = v.nb[5];
        u_if.nighScore6 = v.nb[6];
        u_if.nighScore7 = v.nb[7];
    endtask

    task automatic run_window(input vec_t v, input string tag);
        int  lat_seen = 0;
        bit  ctl_ok   = 1'b1;
        bit  below    = (v.rs < v.th);
        @(negedge clk);
        drive(v);
        u_if.start = 1'b1;
        @(posedge clk);
        #1 u_if.start = 1'b0;
        for (int k = 1; k <= v.lat + 1; k++) begin
            @(negedge clk);
            if (u_if.readEn !== (!below && (k < v.lat))) ctl_ok = 1'b0;
            if (u_if.busy   !== (k <= v.lat))            ctl_ok = 1'b0;
            if (u_if.done   !== (k == v.lat))            ctl_ok = 1'b0;
            if (u_if.done === 1'b1 && lat_seen == 0)     lat_seen = k;
        end
        if (v.pk && model_cnt < CNT_MAX) model_cnt++;
        check({tag, ".latency"},   64'(lat_seen), 64'(v.lat));
        check({tag, ".ctl"},       64'(ctl_ok), 64'(1));
        check({tag, ".isPeak"},    64'(u_if.isPeak), 64'(v.pk));
        check({tag, ".peakScore"}, 64'(u_if.peakScore), v.pk ? 64'(v.rs) : 64'(0));
        check({tag, ".peakCount"}, 64'(u_if.peakCount), 64'(model_cnt));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".outs"},
              {u_if.readEn, u_if.busy, u_if.done, u_if.isPeak, 12'(u_if.peakScore), 4'(u_if.peakCount)},
              '0);
    endtask

    initial begin
        vec_t v;
        int   dcount;

        RESET = 1'b1;
        u_if.start = 1'b0;
        v.rs = '0; v.th = '0; v.nb = '0; v.lat = 0; v.pk = 1'b0;
        drive(v);

        for (int i = 0; i < 8; i++) begin
            tbl[i].rs = '0; tbl[i].th = '0; tbl[i].nb = '0; tbl[i].lat = 0; tbl[i].pk = 1'b0;
        end
        // threshold reject; neighbours irrelevant
        tbl[0].rs = 12'h010; tbl[0].th = 12'h020;
        for (int j = 0; j < 8; j++) tbl[0].nb[j] = 12'hFFF;
        tbl[0].lat = 1; tbl[0].pk = 1'b0;
        // clear peak
        tbl[1].rs = 12'h800;
        for (int j = 0; j < 8; j++) tbl[1].nb[j] = 12'h100;
        tbl[1].lat = 9; tbl[1].pk = 1'b1;
        // early exit at neighbour 2
        tbl[2].rs = 12'h400; tbl[2].nb[2] = 12'h401;
        tbl[2].lat = 4; tbl[2].pk = 1'b0;
        // plateau tie at 1 and 5
        tbl[3].rs = 12'h300; tbl[3].nb[1] = 12'h300; tbl[3].nb[5] = 12'h300;
        // all equal, ref == thresh
        tbl[4].rs = 12'h050; tbl[4].th = 12'h050;
        for (int j = 0; j < 8; j++) tbl[4].nb[j] = 12'h050;
        // tie on the last neighbour at full scale
        tbl[5].rs = 12'hFFF; tbl[5].nb[7] = 12'hFFF;
`ifdef NMS_TIEBREAK_EN
        tbl[3].lat = 7; tbl[3].pk = 1'b0;
        tbl[4].lat = 6; tbl[4].pk = 1'b0;
        tbl[5].lat = 9; tbl[5].pk = 1'b0;
`else
        tbl[3].lat = 9; tbl[3].pk = 1'b1;
        tbl[4].lat = 9; tbl[4].pk = 1'b1;
        tbl[5].lat = 9; tbl[5].pk = 1'b1;
`endif
        // loss at neighbour 0
        tbl[6].rs = 12'h100; tbl[6].nb[0] = 12'h101;
        tbl[6].lat = 2; tbl[6].pk = 1'b0;
        // one below threshold
        tbl[7].rs = 12'h04F; tbl[7].th = 12'h050;
        tbl[7].lat = 1; tbl[7].pk = 1'b0;

        repeat (2) @(negedge clk);
        check_all_zero("reset_held");
        RESET = 1'b0;
        @(negedge clk);
        check_all_zero("reset_released");

        for (int i = 0; i < 8; i++) run_window(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 60; i++) begin
            v.rs = 12'($urandom_range(0, 4095));
            v.th = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095)) : 12'h000;
            for (int j = 0; j < 8; j++) begin
                int r = $urandom_range(0, 9);
                if (r < 7)       v.nb[j] = 12'($urandom_range(0, int'(v.rs)));
                else if (r == 7) v.nb[j] = v.rs;
                else             v.nb[j] = 12'($urandom_range(0, 4095));
            end
            model(v.rs, v.th, v.nb, v.lat, v.pk);
            run_window(v, $sformatf("rnd%0d", i));
        end

        // second start during CMP and another during DONE must both be ignored
        dcount = 0;
        @(negedge clk);
        drive(tbl[1]);
        u_if.start = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (u_if.done === 1'b1) dcount++;
            u_if.start = (k == 3 || k == 9);
        end
        u_if.start = 1'b0;
        if (model_cnt < CNT_MAX) model_cnt++;
        check("busy_ignore.dones", 64'(dcount), 64'(1));
        check("busy_ignore.peakCount", 64'(u_if.peakCount), 64'(model_cnt));

        // reset in cycle 4 of a full-pass window
        dcount = 0;
        @(negedge clk);
        drive(tbl[1]);
        u_if.start = 1'b1;
        @(posedge clk);
        #1 u_if.start = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset.busy_before", 64'(u_if.busy), 64'(1));
        @(negedge clk);
        RESET = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        RESET = 1'b0;
        model_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (u_if.done === 1'b1 || u_if.busy === 1'b1) dcount++;
        end
        check("midreset.no_done", 64'(dcount), 64'(0));
        check("midreset.peakCount", 64'(u_if.peakCount), 64'(0));

        for (int i = 0; i < CNT_MAX + 2; i++) run_window(tbl[1], $sformatf("sat%0d", i));
        check("sat.final", 64'(u_if.peakCount), 64'(CNT_MAX));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
